// File: rtl/hazard_scoreboard.sv
// Hazard control for the 5-stage pipeline with a long-latency multiply/divide
// unit. Produces stalls, flushes and forwarding selects, tracks in-flight
// long-latency destinations and drives the second register-file write port.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int MC_LATENCY   = 8,
  parameter bit MC_PIPELINED = 1'b1,
  parameter int CNT_W        = $clog2(MC_LATENCY + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_dec,
  input  logic                  i_reg_we_dec,
  input  logic                  i_mc_op_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic                  i_load_instr_exec,
  input  logic                  i_mc_issue_exec,
  input  logic                  i_pc_src_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_mem,
  input  logic                  i_reg_we_wb,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic                  o_mc_wb_we,
  output logic [REG_ADDR_W-1:0] o_mc_wb_addr,
  output logic                  o_mc_busy,
  output logic [CNT_W-1:0]      o_mc_inflight
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

  // An issue only creates a scoreboard entry when it targets a real register.
  logic                  issue_valid;
  logic                  mc_wb_we;
  logic [REG_ADDR_W-1:0] mc_wb_addr;
  logic [CNT_W-1:0]      mc_inflight;
  logic                  mc_busy;
  logic                  sb_hit_rs1;
  logic                  sb_hit_rs2;
  logic                  sb_hit_rd;

  assign issue_valid = i_mc_issue_exec && (i_rd_addr_exec != '0);

  if (MC_PIPELINED) begin : g_pipe
    sb_entry_t        sb_q [MC_LATENCY];
    sb_entry_t        sb_d [MC_LATENCY];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Shift register: stage 0 takes the issuing op, last stage is completing.
    always_comb begin
      sb_d[0].valid = issue_valid;
      sb_d[0].rd    = issue_valid ? i_rd_addr_exec : '0;
      for (int i = 1; i < MC_LATENCY; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end

    // In-flight count: up on a new entry, down as the last stage retires.
    always_comb begin
      cnt_d = cnt_q;
      if (issue_valid && !mc_wb_we) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!issue_valid && mc_wb_we) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Scoreboard and count registers; reset drops everything in flight.
    always_ff @(posedge i_clk) begin
      if (i_arst) begin
        for (int i = 0; i < MC_LATENCY; i++) begin
          sb_q[i] <= '0;
        end
        cnt_q <= '0;
      end else begin
        sb_q  <= sb_d;
        cnt_q <= cnt_d;
      end
    end

    // Match decode addresses against every stored entry.
    always_comb begin
      sb_hit_rs1 = 1'b0;
      sb_hit_rs2 = 1'b0;
      sb_hit_rd  = 1'b0;
      for (int i = 0; i < MC_LATENCY; i++) begin
        if (sb_q[i].valid && (sb_q[i].rd == i_rs1_addr_dec)) sb_hit_rs1 = 1'b1;
        if (sb_q[i].valid && (sb_q[i].rd == i_rs2_addr_dec)) sb_hit_rs2 = 1'b1;
        if (sb_q[i].valid && (sb_q[i].rd == i_rd_addr_dec))  sb_hit_rd  = 1'b1;
      end
    end

    assign mc_wb_we    = sb_q[MC_LATENCY-1].valid;
    assign mc_wb_addr  = sb_q[MC_LATENCY-1].rd;
    assign mc_inflight = cnt_q;
  end else begin : g_iter
    sb_entry_t        ent_q;
    sb_entry_t        ent_d;
    logic [CNT_W-1:0] ctr_q;
    logic [CNT_W-1:0] ctr_d;
    logic             done;

    // The op completes in the cycle the down-counter reads one.
    assign done = (ctr_q == CNT_W'(1));

    // Single entry plus down-counter; an issue reloads the full latency.
    always_comb begin
      ent_d = ent_q;
      ctr_d = ctr_q;
      if (i_mc_issue_exec) begin
        ent_d.valid = issue_valid;
        ent_d.rd    = issue_valid ? i_rd_addr_exec : '0;
        ctr_d       = CNT_W'(MC_LATENCY);
      end else begin
        if (done) ent_d = '0;
        if (ctr_q != '0) ctr_d = ctr_q - CNT_W'(1);
      end
    end

    // Entry and counter registers; reset abandons the op in flight.
    always_ff @(posedge i_clk) begin
      if (i_arst) begin
        ent_q <= '0;
        ctr_q <= '0;
      end else begin
        ent_q <= ent_d;
        ctr_q <= ctr_d;
      end
    end

    assign sb_hit_rs1  = ent_q.valid && (ent_q.rd == i_rs1_addr_dec);
    assign sb_hit_rs2  = ent_q.valid && (ent_q.rd == i_rs2_addr_dec);
    assign sb_hit_rd   = ent_q.valid && (ent_q.rd == i_rd_addr_dec);
    assign mc_wb_we    = done && ent_q.valid;
    assign mc_wb_addr  = ent_q.rd;
    assign mc_inflight = {{(CNT_W-1){1'b0}}, (ctr_q != '0)};
  end

  assign mc_busy = (mc_inflight != '0);

  // Memory beats write-back; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  we_mem,
    input logic [REG_ADDR_W-1:0] rd_mem,
    input logic                  we_wb,
    input logic [REG_ADDR_W-1:0] rd_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if ((rs != '0) && we_mem && (rd_mem == rs)) begin
      sel = 2'b10;
    end else if ((rs != '0) && we_wb && (rd_wb == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  logic pend_rs1;
  logic pend_rs2;
  logic pend_rd;
  logic ll_stall;
  logic struct_stall;
  logic load_use_stall;
  logic any_stall;

  // Pending set = stored entries plus the op issuing right now.
  assign pend_rs1 = sb_hit_rs1 || (issue_valid && (i_rd_addr_exec == i_rs1_addr_dec));
  assign pend_rs2 = sb_hit_rs2 || (issue_valid && (i_rd_addr_exec == i_rs2_addr_dec));
  assign pend_rd  = sb_hit_rd  || (issue_valid && (i_rd_addr_exec == i_rd_addr_dec));

  assign ll_stall = ((i_rs1_addr_dec != '0) && pend_rs1) ||
                    ((i_rs2_addr_dec != '0) && pend_rs2) ||
                    (i_reg_we_dec && (i_rd_addr_dec != '0) && pend_rd);

  assign struct_stall = (MC_PIPELINED == 1'b0) && i_mc_op_dec &&
                        (mc_busy || i_mc_issue_exec);

  assign load_use_stall = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                          ((i_rd_addr_exec == i_rs1_addr_dec) ||
                           (i_rd_addr_exec == i_rs2_addr_dec));

  assign any_stall = ll_stall || struct_stall || load_use_stall;

  // A taken branch discards the decode instruction, so it overrides stalls.
  always_comb begin
    o_stall_fetch = 1'b0;
    o_stall_dec   = 1'b0;
    o_flush_dec   = 1'b0;
    o_flush_exec  = 1'b0;
    if (i_pc_src_exec) begin
      o_flush_dec  = 1'b1;
      o_flush_exec = 1'b1;
    end else if (any_stall) begin
      o_stall_fetch = 1'b1;
      o_stall_dec   = 1'b1;
      o_flush_exec  = 1'b1;
    end
  end

  assign o_forward_rs1 = fwd_sel(i_rs1_addr_exec, i_reg_we_mem, i_rd_addr_mem,
                                 i_reg_we_wb, i_rd_addr_wb);
  assign o_forward_rs2 = fwd_sel(i_rs2_addr_exec, i_reg_we_mem, i_rd_addr_mem,
                                 i_reg_we_wb, i_rd_addr_wb);
  assign o_mc_wb_we    = mc_wb_we;
  assign o_mc_wb_addr  = mc_wb_addr;
  assign o_mc_busy     = mc_busy;
  assign o_mc_inflight = mc_inflight;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one pipelined and one iterative instance share
// the stimulus; a list of issued ops (register, issue cycle) predicts outputs.
module tb_hazard_scoreboard;
  localparam int AW  = 5;
  localparam int LAT = 8;
  localparam int CW  = $clog2(LAT + 1);
  localparam int VW  = 4 + 4 + 1 + AW + 1 + CW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst;

  logic [AW-1:0] rs1_dec, rs2_dec, rd_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
  logic          we_dec, mc_op_dec, load_exec, issue_exec, pc_src, we_mem, we_wb;

  logic          pp_sf, pp_sd, pp_fd, pp_fe, pp_we, pp_busy;
  logic [1:0]    pp_f1, pp_f2;
  logic [AW-1:0] pp_wa;
  logic [CW-1:0] pp_cnt;
  logic          it_sf, it_sd, it_fd, it_fe, it_we, it_busy;
  logic [1:0]    it_f1, it_f2;
  logic [AW-1:0] it_wa;
  logic [CW-1:0] it_cnt;

  hazard_scoreboard #(.REG_ADDR_W(AW), .MC_LATENCY(LAT), .MC_PIPELINED(1'b1), .CNT_W(CW)) dut_pipe (
    .i_clk(clk), .i_arst(arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec), .i_rd_addr_dec(rd_dec),
    .i_reg_we_dec(we_dec), .i_mc_op_dec(mc_op_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec), .i_rd_addr_exec(rd_exec),
    .i_load_instr_exec(load_exec), .i_mc_issue_exec(issue_exec), .i_pc_src_exec(pc_src),
    .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb), .i_reg_we_mem(we_mem), .i_reg_we_wb(we_wb),
    .o_stall_fetch(pp_sf), .o_stall_dec(pp_sd), .o_flush_dec(pp_fd), .o_flush_exec(pp_fe),
    .o_forward_rs1(pp_f1), .o_forward_rs2(pp_f2), .o_mc_wb_we(pp_we), .o_mc_wb_addr(pp_wa),
    .o_mc_busy(pp_busy), .o_mc_inflight(pp_cnt));

  hazard_scoreboard #(.REG_ADDR_W(AW), .MC_LATENCY(LAT), .MC_PIPELINED(1'b0), .CNT_W(CW)) dut_iter (
    .i_clk(clk), .i_arst(arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec), .i_rd_addr_dec(rd_dec),
    .i_reg_we_dec(we_dec), .i_mc_op_dec(mc_op_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec), .i_rd_addr_exec(rd_exec),
    .i_load_instr_exec(load_exec), .i_mc_issue_exec(issue_exec), .i_pc_src_exec(pc_src),
    .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb), .i_reg_we_mem(we_mem), .i_reg_we_wb(we_wb),
    .o_stall_fetch(it_sf), .o_stall_dec(it_sd), .o_flush_dec(it_fd), .o_flush_exec(it_fe),
    .o_forward_rs1(it_f1), .o_forward_rs2(it_f2), .o_mc_wb_we(it_we), .o_mc_wb_addr(it_wa),
    .o_mc_busy(it_busy), .o_mc_inflight(it_cnt));

  // reference model: ops issued, each with its destination and issue cycle
  typedef struct {
    int            t;
    logic [AW-1:0] rd;
  } op_t;
  op_t ops[$];
  int  cyc;
  int  n_total, n_pass, n_fail;
  bit  chk_p, chk_i;

  function automatic bit pending(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    if (issue_exec && (rd_exec == r)) return 1'b1;
    foreach (ops[k]) if ((cyc <= ops[k].t + LAT) && (ops[k].rd == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_inflight();
    int n = 0;
    foreach (ops[k]) if ((ops[k].t < cyc) && (cyc <= ops[k].t + LAT)) n++;
    return n;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
    if (rs == '0) return 2'b00;
    if (we_mem && (rd_mem == rs)) return 2'b10;
    if (we_wb && (rd_wb == rs)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval(input bit iter, output logic [VW-1:0] e, output logic ewe);
    logic ll, lu, st, busy, sf, sd, fd, fe, we;
    logic [AW-1:0] wa;
    int n;
    n    = model_inflight();
    busy = (n != 0);
    ll   = pending(rs1_dec) || pending(rs2_dec) || (we_dec && pending(rd_dec));
    lu   = load_exec && (rd_exec != '0) && ((rd_exec == rs1_dec) || (rd_exec == rs2_dec));
    st   = iter && mc_op_dec && (busy || issue_exec);
    sf = 1'b0; sd = 1'b0; fd = 1'b0; fe = 1'b0;
    if (pc_src) begin
      fd = 1'b1; fe = 1'b1;
    end else if (ll || lu || st) begin
      sf = 1'b1; sd = 1'b1; fe = 1'b1;
    end
    we = 1'b0; wa = '0;
    foreach (ops[k]) if (ops[k].t + LAT == cyc) begin we = 1'b1; wa = ops[k].rd; end
    e   = {sf, sd, fd, fe, model_fwd(rs1_exec), model_fwd(rs2_exec), we, wa, busy, CW'(n)};
    ewe = we;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // driver: compare whole output set for this cycle, log issue, advance clock
  task automatic tick(input string tag);
    logic [VW-1:0] e, o;
    logic          ewe;
    #2;
    while ((ops.size() > 0) && (ops[0].t + LAT < cyc)) void'(ops.pop_front());
    if (chk_p) begin
      model_eval(1'b0, e, ewe);
      o = {pp_sf, pp_sd, pp_fd, pp_fe, pp_f1, pp_f2, pp_we, (ewe ? pp_wa : '0), pp_busy, pp_cnt};
      check({tag, "/pipe"}, 32'(o), 32'(e));
    end
    if (chk_i) begin
      model_eval(1'b1, e, ewe);
      o = {it_sf, it_sd, it_fd, it_fe, it_f1, it_f2, it_we, (ewe ? it_wa : '0), it_busy, it_cnt};
      check({tag, "/iter"}, 32'(o), 32'(e));
    end
    if (arst) ops.delete();
    else if (issue_exec && (rd_exec != '0)) ops.push_back('{cyc, rd_exec});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    {rs1_dec, rs2_dec, rd_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb} = '0;
    {we_dec, mc_op_dec, load_exec, issue_exec, pc_src, we_mem, we_wb} = '0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick("reset_pulse");
    arst = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; cyc = 0;
    chk_p = 1'b1; chk_i = 1'b1;
    idle_inputs();
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;

    // reset state
    #1;
    check("reset_inflight", 32'(pp_cnt), 32'(0));
    check("reset_wb_we", 32'(it_we), 32'(0));
    tick("reset_state");

    // forwarding
    rd_mem = 5; rd_wb = 5; we_mem = 1; we_wb = 1; rs1_exec = 5; rs2_exec = 5;
    #1; check("fwd_mem", 32'(pp_f1), 32'(2'b10));
    tick("fwd_mem");
    we_mem = 0;
    #1; check("fwd_wb", 32'(pp_f1), 32'(2'b01));
    tick("fwd_wb");
    rs1_exec = 0;
    #1; check("fwd_x0", 32'(pp_f1), 32'(2'b00));
    tick("fwd_x0");
    idle_inputs();

    // load-use
    load_exec = 1; rd_exec = 7; rs2_dec = 7;
    #1; check("load_use_stall", 32'({pp_sf, pp_sd, pp_fe}), 32'(3'b111));
    tick("load_use");
    load_exec = 0; rd_exec = 0;
    #1; check("load_use_release", 32'(pp_sf), 32'(0));
    tick("load_use_release");
    load_exec = 1; rd_exec = 0; rs2_dec = 0;
    #1; check("load_x0", 32'(pp_sf), 32'(0));
    tick("load_x0");
    idle_inputs();

    // long-latency RAW: issue x3 at T, decode reads x3
    rs1_dec = 3;
    for (int k = 0; k <= LAT + 1; k++) begin
      issue_exec = (k == 0);
      rd_exec    = (k == 0) ? 5'd3 : 5'd0;
      #1;
      if (k == LAT) check("raw_wb", 32'({pp_we, pp_wa, pp_sf}), 32'({1'b1, 5'd3, 1'b1}));
      if (k == LAT + 1) check("raw_release", 32'(pp_sf), 32'(0));
      tick("raw");
    end
    idle_inputs();

    // pipelined burst x1, x2, x3 with a WAW on x2
    chk_i = 1'b0;
    for (int k = 0; k <= LAT + 3; k++) begin
      issue_exec = (k < 3);
      rd_exec    = (k < 3) ? 5'(k + 1) : 5'd0;
      we_dec     = (k >= 1);
      rd_dec     = 5'd2;
      #1;
      if ((k >= 1) && (k <= 3)) check("burst_inflight", 32'(pp_cnt), 32'(k));
      if ((k >= LAT) && (k <= LAT + 2)) check("burst_wb", 32'({pp_we, pp_wa}), 32'({1'b1, 5'(k - LAT + 1)}));
      if (k == LAT + 1) check("waw_hold", 32'(pp_sf), 32'(1));
      if (k == LAT + 2) check("waw_release", 32'(pp_sf), 32'(0));
      tick("burst");
    end
    idle_inputs();
    do_reset();
    chk_i = 1'b1;

    // iterative: second MC op in decode waits for the unit; branch overrides
    mc_op_dec = 1;
    for (int k = 0; k <= LAT + 1; k++) begin
      issue_exec = (k == 0);
      rd_exec    = (k == 0) ? 5'd4 : 5'd0;
      pc_src     = (k == 3);
      #1;
      if (k == 3) check("iter_branch", 32'({it_fd, it_fe, it_sf, it_sd}), 32'(4'b1100));
      if (k == 5) check("iter_struct", 32'(it_sf), 32'(1));
      if (k == LAT) check("iter_done", 32'({it_we, it_wa, it_sf}), 32'({1'b1, 5'd4, 1'b1}));
      if (k == LAT + 1) check("iter_release", 32'(it_sf), 32'(0));
      tick("iter");
    end
    idle_inputs();

    // reset mid-flight
    chk_i = 1'b0;
    rs1_dec = 6;
    for (int k = 0; k < 3; k++) begin
      issue_exec = 1; rd_exec = 5'(5 + k);
      tick("midflight_issue");
    end
    issue_exec = 0; rd_exec = 0;
    #1; check("midflight_stall", 32'({pp_sf, pp_cnt}), 32'({1'b1, CW'(3)}));
    tick("midflight_hold");
    do_reset();
    #1; check("post_reset", 32'({pp_sf, pp_cnt}), 32'(0));
    for (int k = 0; k < LAT + 2; k++) begin
      #1; check("post_reset_no_wb", 32'(pp_we), 32'(0));
      tick("post_reset");
    end
    idle_inputs();
    do_reset();
    chk_i = 1'b1;

    // random, pipelined-style traffic (iterative instance not compared)
    chk_i = 1'b0;
    for (int n = 0; n < 300; n++) begin
      issue_exec = ($urandom_range(0, 1) == 1);
      load_exec  = !issue_exec && ($urandom_range(0, 3) == 0);
      rd_exec    = issue_exec ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
      rs1_dec = 5'($urandom_range(0, 7)); rs2_dec = 5'($urandom_range(0, 7));
      rd_dec  = 5'($urandom_range(0, 7)); we_dec  = 1'($urandom_range(0, 1));
      mc_op_dec = 1'($urandom_range(0, 1)); pc_src = ($urandom_range(0, 7) == 0);
      rs1_exec = 5'($urandom_range(0, 7)); rs2_exec = 5'($urandom_range(0, 7));
      rd_mem = 5'($urandom_range(0, 7)); rd_wb = 5'($urandom_range(0, 7));
      we_mem = 1'($urandom_range(0, 1)); we_wb = 1'($urandom_range(0, 1));
      tick("rand_pipe");
    end
    idle_inputs();
    do_reset();
    chk_i = 1'b1;

    // random traffic with one op at a time (both instances compared)
    for (int n = 0; n < 400; n++) begin
      issue_exec = (model_inflight() == 0) && ($urandom_range(0, 2) == 0);
      load_exec  = !issue_exec && ($urandom_range(0, 3) == 0);
      rd_exec    = issue_exec ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
      rs1_dec = 5'($urandom_range(0, 7)); rs2_dec = 5'($urandom_range(0, 7));
      rd_dec  = 5'($urandom_range(0, 7)); we_dec  = 1'($urandom_range(0, 1));
      mc_op_dec = 1'($urandom_range(0, 1)); pc_src = ($urandom_range(0, 7) == 0);
      rs1_exec = 5'($urandom_range(0, 7)); rs2_exec = 5'($urandom_range(0, 7));
      rd_mem = 5'($urandom_range(0, 7)); rd_wb = 5'($urandom_range(0, 7));
      we_mem = 1'($urandom_range(0, 1)); we_wb = 1'($urandom_range(0, 1));
      tick("rand_iter");
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard-control block for the 5-stage RV64 pipeline, extended for a long-latency functional unit (multiply/divide) with configurable latency and pipelined or iterative mode. It produces fetch/decode stalls, decode/execute flushes and the 2-bit rs1/rs2 forwarding selects. It keeps a scoreboard of in-flight long-latency destination registers and drives the dedicated second register-file write port that retires their results.

## Interface
- REG_ADDR_W, 5: register address width.
- MC_LATENCY, 8: cycles from issue to completion of a long-latency op; legal range 2..64.
- MC_PIPELINED, 1: 1 = unit accepts one op per cycle; 0 = iterative unit, one op in flight.
- CNT_W, $clog2(MC_LATENCY+1): width of the in-flight count.

- i_clk  in  1  clock.
- i_arst  in  1  reset. Synchronous, active-high.
- i_rs1_addr_dec, i_rs2_addr_dec, i_rd_addr_dec  in  REG_ADDR_W  decode-stage operand and destination addresses.
- i_reg_we_dec  in  1  decode instruction writes rd.
- i_mc_op_dec  in  1  decode instruction is a long-latency op.
- i_rs1_addr_exec, i_rs2_addr_exec, i_rd_addr_exec  in  REG_ADDR_W  execute-stage addresses.
- i_load_instr_exec  in  1  execute instruction is a load.
- i_mc_issue_exec  in  1  execute instruction is a long-latency op; it issues this cycle.
- i_pc_src_exec  in  1  taken branch/jump in execute.
- i_rd_addr_mem, i_rd_addr_wb  in  REG_ADDR_W  destination addresses in memory and write-back.
- i_reg_we_mem, i_reg_we_wb  in  1  write enables in memory and write-back.
- o_stall_fetch, o_stall_dec  out  1  hold the PC and the fetch→decode register.
- o_flush_dec, o_flush_exec  out  1  clear the fetch→decode and decode→execute registers.
- o_forward_rs1, o_forward_rs2  out  2  00 = register file, 01 = write-back result, 10 = memory forward value.
- o_mc_wb_we  out  1  long-latency result written this cycle.
- o_mc_wb_addr  out  REG_ADDR_W  destination of that result.
- o_mc_busy  out  1  any op in flight.
- o_mc_inflight  out  CNT_W  number of ops in flight.

## Operation
- **Forwarding (combinational, rs1 and rs2 independently):**
  - If rs_exec != 0, i_reg_we_mem and rd_mem == rs_exec: select 10.
  - Else if rs_exec != 0, i_reg_we_wb and rd_wb == rs_exec: select 01.
  - Else: select 00. Memory has priority over write-back.
- **Scoreboard, pipelined mode:** a shift register of MC_LATENCY entries {valid, rd}.
  - Stage 1 loads {i_mc_issue_exec && i_rd_addr_exec != 0, i_rd_addr_exec} at each edge.
  - The last stage drives o_mc_wb_we / o_mc_wb_addr.
- **Scoreboard, iterative mode:** one entry {valid, rd} plus a down-counter.
  - On issue the counter loads MC_LATENCY and decrements every cycle.
  - Completion is the cycle in which the counter == 1.
- **Pending set:** all valid entries (including the completing one), plus i_rd_addr_exec when i_mc_issue_exec is high and i_rd_addr_exec != 0.
- **Long-latency RAW/WAW stall:** raised when i_rs1_addr_dec or i_rs2_addr_dec (nonzero) is in the pending set, or when i_reg_we_dec is high and i_rd_addr_dec is in the pending set.
- **Structural stall (iterative mode only):** i_mc_op_dec while o_mc_busy or i_mc_issue_exec.
- **Load-use stall:** i_load_instr_exec, i_rd_addr_exec != 0, and i_rd_addr_exec equals either decode source.
- **Any stall** sets o_stall_fetch = o_stall_dec = 1 and o_flush_exec = 1 (bubble).
- **Taken branch (i_pc_src_exec):** o_flush_dec = o_flush_exec = 1 and both stalls are forced to 0. The branch overrides all stalls because the decode instruction is being discarded.
- Issue is never blocked: the execute stage always advances.
- Register x0 never matches, is never forwarded and is never written by o_mc_wb_we.

## Timing
- **Latency:** issue in cycle T (i_mc_issue_exec high). o_mc_wb_we is high in cycle T+MC_LATENCY and the register file writes at the end of that cycle.
- **Dependent-op stall:** a dependent decode instruction stalls in cycles T..T+MC_LATENCY and is released in T+MC_LATENCY+1, when it reads the updated register file.
- **o_mc_inflight:** increments at the edge after issue and decrements at the edge ending the completion cycle. Simultaneous issue and completion leave it unchanged.
- **Combinational outputs:** o_mc_busy = (o_mc_inflight != 0). Stalls, flushes and forwards are combinational with no added latency.
- **Reset:**
  - Asserting i_arst at a clock edge clears all entries, the counter and o_mc_inflight.
  - The following cycle shows all outputs 0 and forward selects 00.
  - In-flight ops are dropped; no o_mc_wb_we occurs after reset.
- **Pipelined mode:** up to MC_LATENCY ops in flight. The count saturates structurally because at most one op can issue per cycle.

## Test plan
- **Forwarding:** rd_mem = rd_wb = 5, both write enables high, rs1_exec = 5 → o_forward_rs1 = 10. Drop i_reg_we_mem → 01. Set rs1_exec = 0 → 00.
- **Load-use:** load to x7 in exec, decode rs2 = 7 → stall_fetch, stall_dec and flush_exec = 1 for exactly one cycle. With rd = 0 → no stall.
- **Long-latency RAW (MC_LATENCY = 8):** issue to x3 at T, decode reads x3 → stalls in T..T+8. o_mc_wb_we = 1 with addr 3 at T+8. Released at T+9.
- **Pipelined burst:** issue to x1, x2, x3 on consecutive cycles → o_mc_inflight goes 1, 2, 3. Completions occur at T+8, T+9, T+10 in order. A WAW stall is raised for a decode write to x2 until T+9.
- **Iterative mode (MC_PIPELINED = 0):** a second MC op in decode stalls until the cycle after the first op completes. A taken branch during that stall → flush_dec = flush_exec = 1 and stalls = 0.
- **Reset mid-flight:** 3 ops in flight, i_arst pulsed → o_mc_inflight = 0, no o_mc_wb_we afterwards, and the previously stalled decode is released.
